rvh_l1d_req_enc: RTL and testbench
==================================

// Module: rvh_l1d_req_enc
// PURPOSE
//  LSU-side encoder/issuer feeding the L1D request decoder. Accepts in-order memory uops carrying a decoded request type
//  (ld/st/lr/sc/amo, size, unsigned, amo kind) and encodes each into an LDU_*/STU_* opcode from uop_encoding_pkg.
//  Buffers encoded requests in an in-order FIFO and issues the head on the L1D load or store channel via valid/ready.
//  Rejects illegal type combinations with an error pulse.
// PARAMETERS
//  DEPTH      4   FIFO entries, power of two, >=2
//  PADDR_W    56  physical address width
//  TAG_W      8   request tag width, returned unchanged with the request
// PORTS
//  clk                   in   1             clock
//  rst                   in   1             async reset, active low
//  flush_i               in   1             synchronous drop of all buffered requests
//  req_vld_i             in   1             uop request valid
//  req_rdy_o             out  1             request accepted when vld&rdy
//  req_is_ld_i/_st_i/_lr_i/_sc_i/_amo_i in 1 each   one-hot request class
//  req_size_i            in   2             0=B 1=H 2=W 3=D
//  req_unsigned_i        in   1             zero-extend load / unsigned AMO max/min
//  req_amo_type_i        in   $bits(amo_type) AMOSWAP/ADD/AND/OR/XOR/MAX/MIN (rvh_l1d_pkg)
//  req_paddr_i           in   PADDR_W       physical address
//  req_data_i            in   64            store/AMO operand
//  req_tag_i             in   TAG_W         request tag
//  req_err_o             out  1             1-cycle pulse: accepted request was illegal and dropped
//  l1d_ld_req_vld_o      out  1             load channel valid
//  l1d_ld_req_rdy_i      in   1             load channel ready
//  l1d_ld_req_opcode_o   out  LDU_OP_WIDTH  encoded LDU_* opcode
//  l1d_ld_req_paddr_o/_tag_o out PADDR_W/TAG_W
//  l1d_st_req_vld_o      out  1             store channel valid (st, lr, sc, amo)
//  l1d_st_req_rdy_i      in   1             store channel ready
//  l1d_st_req_opcode_o   out  STU_OP_WIDTH  encoded STU_* opcode
//  l1d_st_req_paddr_o/_data_o/_tag_o out PADDR_W/64/TAG_W
//  fifo_cnt_o            out  $clog2(DEPTH)+1 current occupancy
// BEHAVIOUR
//  Reset: FIFO empty, cnt=0, rd/wr ptrs=0, req_err_o=0, both vld_o=0; opcode/paddr/data/tag outputs 0.
//  req_rdy_o = (cnt<DEPTH) & ~flush_i; no same-cycle pass-through when full.
//  Encoding at enqueue: ld: size B/H/W -> LB/LH/LW or LBU/LHU/LWU by unsigned; D -> LD.
//   st: SB/SH/SW/SD. lr: W->LRW, D->LRD. sc: W->SCW, D->SCD. amo: type x {W,D}, MAX/MIN with unsigned -> *U variants.
//  Illegal (accepted, not enqueued, req_err_o=1 next cycle): class not one-hot; lr/sc/amo with size B/H;
//   ld D with unsigned; unsigned on AMO other than MAX/MIN; unsigned on st/lr/sc.
//  Latency: legal request accepted at cycle N is visible on its channel at N+1 at the earliest (registered FIFO).
//  Issue: head entry only, strictly in order; ld head -> ld channel, others -> st channel; other channel vld=0.
//   Head pops on vld_o & rdy_i; vld_o/payload held stable until handshake.
//  Simultaneous enq+deq: cnt unchanged; ptrs wrap modulo DEPTH.
//  flush_i: next cycle cnt=0, ptrs=0, vld_o=0; a request offered in the flush cycle is not accepted (rdy=0),
//   a handshake on the output in the flush cycle still completes.
//  Async reset mid-transfer: immediate return to reset state; in-flight requests discarded.
// TESTING
//  ld size=0 unsigned=1 tag=5 -> cycle+1 ld_vld=1 opcode=LDU_LBU tag=5; st_vld=0.
//  amo MAX size=3 unsigned=1 -> st opcode=STU_AMOMAXUD; amo ADD size=2 -> STU_AMOADDW.
//  lr size=1 -> req_err_o pulse 1 cycle, cnt stays 0, no channel valid.
//  Fill DEPTH=4 with st_rdy=0 -> req_rdy_o=0 at cnt=4; enq+deq at cnt=3 keeps cnt=3.
//  ld,st,ld order with ld_rdy=1 st_rdy=0 -> only first ld issues; second ld blocked behind st.
//  cnt=3 then flush_i -> cnt=0, vld_o=0 next cycle; rst low mid-stream -> all outputs to reset values.

Source files
------------

// File: rtl/rvh_l1d_req_enc.sv
// rvh_l1d_req_enc: encodes LSU memory uops into LDU_*/STU_* opcodes and issues them
// in order to the L1D load/store channels through a small registered FIFO.
package uop_encoding_pkg;
    localparam int LDU_OP_WIDTH = 3;
    localparam int STU_OP_WIDTH = 5;
    localparam logic [LDU_OP_WIDTH-1:0] LDU_LB  = 3'd0;
    localparam logic [LDU_OP_WIDTH-1:0] LDU_LH  = 3'd1;
    localparam logic [LDU_OP_WIDTH-1:0] LDU_LW  = 3'd2;
    localparam logic [LDU_OP_WIDTH-1:0] LDU_LD  = 3'd3;
    localparam logic [LDU_OP_WIDTH-1:0] LDU_LBU = 3'd4;
    localparam logic [LDU_OP_WIDTH-1:0] LDU_LHU = 3'd5;
    localparam logic [LDU_OP_WIDTH-1:0] LDU_LWU = 3'd6;
    localparam logic [STU_OP_WIDTH-1:0] STU_SB       = 5'd0;
    localparam logic [STU_OP_WIDTH-1:0] STU_SH       = 5'd1;
    localparam logic [STU_OP_WIDTH-1:0] STU_SW       = 5'd2;
    localparam logic [STU_OP_WIDTH-1:0] STU_SD       = 5'd3;
    localparam logic [STU_OP_WIDTH-1:0] STU_LRW      = 5'd4;
    localparam logic [STU_OP_WIDTH-1:0] STU_LRD      = 5'd5;
    localparam logic [STU_OP_WIDTH-1:0] STU_SCW      = 5'd6;
    localparam logic [STU_OP_WIDTH-1:0] STU_SCD      = 5'd7;
    localparam logic [STU_OP_WIDTH-1:0] STU_AMOSWAPW = 5'd8;
    localparam logic [STU_OP_WIDTH-1:0] STU_AMOSWAPD = 5'd9;
    localparam logic [STU_OP_WIDTH-1:0] STU_AMOADDW  = 5'd10;
    localparam logic [STU_OP_WIDTH-1:0] STU_AMOADDD  = 5'd11;
    localparam logic [STU_OP_WIDTH-1:0] STU_AMOANDW  = 5'd12;
    localparam logic [STU_OP_WIDTH-1:0] STU_AMOANDD  = 5'd13;
    localparam logic [STU_OP_WIDTH-1:0] STU_AMOORW   = 5'd14;
    localparam logic [STU_OP_WIDTH-1:0] STU_AMOORD   = 5'd15;
    localparam logic [STU_OP_WIDTH-1:0] STU_AMOXORW  = 5'd16;
    localparam logic [STU_OP_WIDTH-1:0] STU_AMOXORD  = 5'd17;
    localparam logic [STU_OP_WIDTH-1:0] STU_AMOMAXW  = 5'd18;
    localparam logic [STU_OP_WIDTH-1:0] STU_AMOMAXD  = 5'd19;
    localparam logic [STU_OP_WIDTH-1:0] STU_AMOMAXUW = 5'd20;
    localparam logic [STU_OP_WIDTH-1:0] STU_AMOMAXUD = 5'd21;
    localparam logic [STU_OP_WIDTH-1:0] STU_AMOMINW  = 5'd22;
    localparam logic [STU_OP_WIDTH-1:0] STU_AMOMIND  = 5'd23;
    localparam logic [STU_OP_WIDTH-1:0] STU_AMOMINUW = 5'd24;
    localparam logic [STU_OP_WIDTH-1:0] STU_AMOMINUD = 5'd25;
endpackage

package rvh_l1d_pkg;
    typedef enum logic [2:0] {AMOSWAP, AMOADD, AMOAND, AMOOR, AMOXOR, AMOMAX, AMOMIN} amo_type_t;
endpackage

module rvh_l1d_req_enc
    import uop_encoding_pkg::*;
    import rvh_l1d_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int PADDR_W = 56,
    parameter int TAG_W   = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush_i,
    input  logic                      req_vld_i,
    output logic                      req_rdy_o,
    input  logic                      req_is_ld_i,
    input  logic                      req_is_st_i,
    input  logic                      req_is_lr_i,
    input  logic                      req_is_sc_i,
    input  logic                      req_is_amo_i,
    input  logic [1:0]                req_size_i,
    input  logic                      req_unsigned_i,
    input  amo_type_t                 req_amo_type_i,
    input  logic [PADDR_W-1:0]        req_paddr_i,
    input  logic [63:0]               req_data_i,
    input  logic [TAG_W-1:0]          req_tag_i,
    output logic                      req_err_o,
    output logic                      l1d_ld_req_vld_o,
    input  logic                      l1d_ld_req_rdy_i,
    output logic [LDU_OP_WIDTH-1:0]   l1d_ld_req_opcode_o,
    output logic [PADDR_W-1:0]        l1d_ld_req_paddr_o,
    output logic [TAG_W-1:0]          l1d_ld_req_tag_o,
    output logic                      l1d_st_req_vld_o,
    input  logic                      l1d_st_req_rdy_i,
    output logic [STU_OP_WIDTH-1:0]   l1d_st_req_opcode_o,
    output logic [PADDR_W-1:0]        l1d_st_req_paddr_o,
    output logic [63:0]               l1d_st_req_data_o,
    output logic [TAG_W-1:0]          l1d_st_req_tag_o,
    output logic [$clog2(DEPTH):0]    fifo_cnt_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL = DEPTH[PTR_W:0];

    typedef struct packed {
        logic                    is_ld;
        logic [STU_OP_WIDTH-1:0] op;
        logic [PADDR_W-1:0]      paddr;
        logic [63:0]             data;
        logic [TAG_W-1:0]        tag;
    } entry_t;

    entry_t                  r_mem [DEPTH];
    logic [PTR_W-1:0]        r_wr_ptr;
    logic [PTR_W-1:0]        r_rd_ptr;
    logic [PTR_W:0]          r_cnt;
    logic                    r_err;
    logic [4:0]              w_cls;
    logic                    w_onehot;
    logic                    w_illegal;
    logic                    w_is_d;
    logic                    w_acc;
    logic                    w_enq;
    logic                    w_deq;
    logic                    w_vld;
    logic [LDU_OP_WIDTH-1:0] w_ld_op;
    logic [STU_OP_WIDTH-1:0] w_amo_op;
    logic [STU_OP_WIDTH-1:0] w_op;
    entry_t                  w_head;
    entry_t                  w_new;

    assign w_cls    = {req_is_ld_i, req_is_st_i, req_is_lr_i, req_is_sc_i, req_is_amo_i};
    assign w_onehot = (w_cls != 5'd0) && ((w_cls & (w_cls - 5'd1)) == 5'd0);
    assign w_is_d   = req_size_i[0];
    assign w_illegal = !w_onehot
                    || ((req_is_lr_i || req_is_sc_i || req_is_amo_i) && !req_size_i[1])
                    || (req_is_ld_i && req_size_i == 2'd3 && req_unsigned_i)
                    || (req_is_amo_i && req_unsigned_i && req_amo_type_i != AMOMAX && req_amo_type_i != AMOMIN)
                    || ((req_is_st_i || req_is_lr_i || req_is_sc_i) && req_unsigned_i);

    always_comb begin
        w_ld_op = req_size_i == 2'd3 ? LDU_LD :
                  req_unsigned_i ? (req_size_i == 2'd0 ? LDU_LBU : req_size_i == 2'd1 ? LDU_LHU : LDU_LWU) :
                                   (req_size_i == 2'd0 ? LDU_LB  : req_size_i == 2'd1 ? LDU_LH  : LDU_LW);
    end

    always_comb begin
        w_amo_op = w_is_d ? STU_AMOSWAPD : STU_AMOSWAPW;
        case (req_amo_type_i)
            AMOADD:  w_amo_op = w_is_d ? STU_AMOADDD : STU_AMOADDW;
            AMOAND:  w_amo_op = w_is_d ? STU_AMOANDD : STU_AMOANDW;
            AMOOR:   w_amo_op = w_is_d ? STU_AMOORD  : STU_AMOORW;
            AMOXOR:  w_amo_op = w_is_d ? STU_AMOXORD : STU_AMOXORW;
            AMOMAX:  w_amo_op = req_unsigned_i ? (w_is_d ? STU_AMOMAXUD : STU_AMOMAXUW)
                                               : (w_is_d ? STU_AMOMAXD  : STU_AMOMAXW);
            AMOMIN:  w_amo_op = req_unsigned_i ? (w_is_d ? STU_AMOMINUD : STU_AMOMINUW)
                                               : (w_is_d ? STU_AMOMIND  : STU_AMOMINW);
            default: ;
        endcase
    end

    // load opcodes share the entry's opcode field, zero-extended
    always_comb begin
        w_op = req_is_ld_i ? {{(STU_OP_WIDTH-LDU_OP_WIDTH){1'b0}}, w_ld_op} :
               req_is_st_i ? (req_size_i == 2'd0 ? STU_SB : req_size_i == 2'd1 ? STU_SH :
                              req_size_i == 2'd2 ? STU_SW : STU_SD) :
               req_is_lr_i ? (w_is_d ? STU_LRD : STU_LRW) :
               req_is_sc_i ? (w_is_d ? STU_SCD : STU_SCW) : w_amo_op;
    end

    assign w_new     = '{is_ld: req_is_ld_i, op: w_op, paddr: req_paddr_i, data: req_data_i, tag: req_tag_i};
    assign req_rdy_o = (r_cnt < FULL) && !flush_i;
    assign w_acc     = req_vld_i && req_rdy_o;
    assign w_enq     = w_acc && !w_illegal;
    assign w_vld     = r_cnt != '0;
    assign w_head    = r_mem[r_rd_ptr];
    assign w_deq     = (l1d_ld_req_vld_o && l1d_ld_req_rdy_i) || (l1d_st_req_vld_o && l1d_st_req_rdy_i);

    assign l1d_ld_req_vld_o    = w_vld && w_head.is_ld;
    assign l1d_st_req_vld_o    = w_vld && !w_head.is_ld;
    assign l1d_ld_req_opcode_o = l1d_ld_req_vld_o ? w_head.op[LDU_OP_WIDTH-1:0] : '0;
    assign l1d_ld_req_paddr_o  = l1d_ld_req_vld_o ? w_head.paddr : '0;
    assign l1d_ld_req_tag_o    = l1d_ld_req_vld_o ? w_head.tag : '0;
    assign l1d_st_req_opcode_o = l1d_st_req_vld_o ? w_head.op : '0;
    assign l1d_st_req_paddr_o  = l1d_st_req_vld_o ? w_head.paddr : '0;
    assign l1d_st_req_data_o   = l1d_st_req_vld_o ? w_head.data : '0;
    assign l1d_st_req_tag_o    = l1d_st_req_vld_o ? w_head.tag : '0;
    assign req_err_o           = r_err;
    assign fifo_cnt_o          = r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            r_err    <= 1'b0;
        end else begin
            r_err <= w_acc && w_illegal;
            if (flush_i) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_cnt    <= '0;
            end else begin
                if (w_enq) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                if (w_deq) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                r_cnt <= r_cnt + {{PTR_W{1'b0}}, w_enq} - {{PTR_W{1'b0}}, w_deq};
            end
        end
    end

    // storage needs no reset: outputs are gated by occupancy
    always_ff @(posedge clk) begin
        if (w_enq) r_mem[r_wr_ptr] <= w_new;
    end
endmodule

// File: tb/tb_rvh_l1d_req_enc.sv
// tb_rvh_l1d_req_enc: randomized + directed scoreboard bench for rvh_l1d_req_enc,
// checked against a rule-level encoding model and an in-order expectation queue.
module tb_rvh_l1d_req_enc;
    import uop_encoding_pkg::*;
    import rvh_l1d_pkg::*;

    localparam int DEPTH = 4;
    localparam bit [4:0] C_LD = 5'b10000, C_ST = 5'b01000, C_LR = 5'b00100, C_SC = 5'b00010, C_AMO = 5'b00001;

    logic clk = 1'b0, rst = 1'b0, flush_i = 1'b0, req_vld_i = 1'b0;
    logic req_is_ld_i = 1'b0, req_is_st_i = 1'b0, req_is_lr_i = 1'b0, req_is_sc_i = 1'b0, req_is_amo_i = 1'b0;
    logic [1:0] req_size_i = '0;
    logic req_unsigned_i = 1'b0;
    amo_type_t req_amo_type_i = AMOSWAP;
    logic [55:0] req_paddr_i = '0;
    logic [63:0] req_data_i = '0;
    logic [7:0] req_tag_i = '0;
    logic req_rdy_o, req_err_o;
    logic l1d_ld_req_vld_o, l1d_ld_req_rdy_i = 1'b0;
    logic [LDU_OP_WIDTH-1:0] l1d_ld_req_opcode_o;
    logic [55:0] l1d_ld_req_paddr_o;
    logic [7:0] l1d_ld_req_tag_o;
    logic l1d_st_req_vld_o, l1d_st_req_rdy_i = 1'b0;
    logic [STU_OP_WIDTH-1:0] l1d_st_req_opcode_o;
    logic [55:0] l1d_st_req_paddr_o;
    logic [63:0] l1d_st_req_data_o;
    logic [7:0] l1d_st_req_tag_o;
    logic [2:0] fifo_cnt_o;

    rvh_l1d_req_enc #(.DEPTH(DEPTH), .PADDR_W(56), .TAG_W(8)) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i), .req_vld_i(req_vld_i), .req_rdy_o(req_rdy_o),
        .req_is_ld_i(req_is_ld_i), .req_is_st_i(req_is_st_i), .req_is_lr_i(req_is_lr_i),
        .req_is_sc_i(req_is_sc_i), .req_is_amo_i(req_is_amo_i), .req_size_i(req_size_i),
        .req_unsigned_i(req_unsigned_i), .req_amo_type_i(req_amo_type_i), .req_paddr_i(req_paddr_i),
        .req_data_i(req_data_i), .req_tag_i(req_tag_i), .req_err_o(req_err_o),
        .l1d_ld_req_vld_o(l1d_ld_req_vld_o), .l1d_ld_req_rdy_i(l1d_ld_req_rdy_i),
        .l1d_ld_req_opcode_o(l1d_ld_req_opcode_o), .l1d_ld_req_paddr_o(l1d_ld_req_paddr_o),
        .l1d_ld_req_tag_o(l1d_ld_req_tag_o), .l1d_st_req_vld_o(l1d_st_req_vld_o),
        .l1d_st_req_rdy_i(l1d_st_req_rdy_i), .l1d_st_req_opcode_o(l1d_st_req_opcode_o),
        .l1d_st_req_paddr_o(l1d_st_req_paddr_o), .l1d_st_req_data_o(l1d_st_req_data_o),
        .l1d_st_req_tag_o(l1d_st_req_tag_o), .fifo_cnt_o(fifo_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_ld;
        int          op;
        logic [55:0] paddr;
        logic [63:0] data;
        logic [7:0]  tag;
    } exp_t;

    exp_t q[$];
    int checks = 0, failures = 0;
    bit exp_err = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // cls bit order: {ld, st, lr, sc, amo}
    function automatic bit legal(input bit [4:0] cls, input bit [1:0] sz, input bit u, input amo_type_t t);
        if ($countones(cls) != 1) return 1'b0;
        if (cls[4]) return !(sz == 2'd3 && u);
        if (cls[3]) return !u;
        if (sz < 2'd2) return 1'b0;
        if (cls[0]) return !u || t == AMOMAX || t == AMOMIN;
        return !u;
    endfunction

    function automatic int enc(input bit [4:0] cls, input bit [1:0] sz, input bit u, input amo_type_t t);
        bit d = (sz == 2'd3);
        if (cls[4]) begin
            case (sz)
                2'd0: return u ? int'(LDU_LBU) : int'(LDU_LB);
                2'd1: return u ? int'(LDU_LHU) : int'(LDU_LH);
                2'd2: return u ? int'(LDU_LWU) : int'(LDU_LW);
                default: return int'(LDU_LD);
            endcase
        end
        if (cls[3]) begin
            case (sz)
                2'd0: return int'(STU_SB);
                2'd1: return int'(STU_SH);
                2'd2: return int'(STU_SW);
                default: return int'(STU_SD);
            endcase
        end
        if (cls[2]) return d ? int'(STU_LRD) : int'(STU_LRW);
        if (cls[1]) return d ? int'(STU_SCD) : int'(STU_SCW);
        case (t)
            AMOSWAP: return d ? int'(STU_AMOSWAPD) : int'(STU_AMOSWAPW);
            AMOADD:  return d ? int'(STU_AMOADDD) : int'(STU_AMOADDW);
            AMOAND:  return d ? int'(STU_AMOANDD) : int'(STU_AMOANDW);
            AMOOR:   return d ? int'(STU_AMOORD) : int'(STU_AMOORW);
            AMOXOR:  return d ? int'(STU_AMOXORD) : int'(STU_AMOXORW);
            AMOMAX:  return u ? (d ? int'(STU_AMOMAXUD) : int'(STU_AMOMAXUW)) : (d ? int'(STU_AMOMAXD) : int'(STU_AMOMAXW));
            default: return u ? (d ? int'(STU_AMOMINUD) : int'(STU_AMOMINUW)) : (d ? int'(STU_AMOMIND) : int'(STU_AMOMINW));
        endcase
    endfunction

    // monitor: checks handshake state each cycle and retires the head on handshake
    always @(negedge clk) begin
        if (rst) begin
            chk("req_rdy", req_rdy_o, 64'((q.size() < DEPTH) && !flush_i));
            chk("fifo_cnt", fifo_cnt_o, 64'(q.size()));
            chk("req_err", req_err_o, 64'(exp_err));
            if (q.size() > 0) begin
                chk("ld_vld", l1d_ld_req_vld_o, 64'(q[0].is_ld));
                chk("st_vld", l1d_st_req_vld_o, 64'(!q[0].is_ld));
                if (q[0].is_ld) begin
                    chk("ld_opcode", l1d_ld_req_opcode_o, 64'(q[0].op));
                    chk("ld_paddr", l1d_ld_req_paddr_o, q[0].paddr);
                    chk("ld_tag", l1d_ld_req_tag_o, q[0].tag);
                end else begin
                    chk("st_opcode", l1d_st_req_opcode_o, 64'(q[0].op));
                    chk("st_paddr", l1d_st_req_paddr_o, q[0].paddr);
                    chk("st_data", l1d_st_req_data_o, q[0].data);
                    chk("st_tag", l1d_st_req_tag_o, q[0].tag);
                end
                if (q[0].is_ld ? l1d_ld_req_rdy_i : l1d_st_req_rdy_i) void'(q.pop_front());
            end else begin
                chk("ld_vld_idle", l1d_ld_req_vld_o, 64'd0);
                chk("st_vld_idle", l1d_st_req_vld_o, 64'd0);
            end
        end
    end

    // one clock of stimulus; entered and left 1 time unit after a rising edge
    task automatic cyc(input bit vld, input bit [4:0] cls, input bit [1:0] sz, input bit u,
                       input amo_type_t t, input bit lrdy, input bit srdy, input bit fl);
        logic [63:0] r64;
        bit acc, ok;
        exp_t e;
        r64 = {$urandom(), $urandom()};
        req_vld_i = vld;
        {req_is_ld_i, req_is_st_i, req_is_lr_i, req_is_sc_i, req_is_amo_i} = cls;
        req_size_i = sz;
        req_unsigned_i = u;
        req_amo_type_i = t;
        req_paddr_i = r64[55:0];
        req_data_i = {$urandom(), $urandom()};
        req_tag_i = 8'($urandom());
        l1d_ld_req_rdy_i = lrdy;
        l1d_st_req_rdy_i = srdy;
        flush_i = fl;
        ok = legal(cls, sz, u, t);
        e = '{is_ld: cls[4], op: enc(cls, sz, u, t), paddr: req_paddr_i, data: req_data_i, tag: req_tag_i};
        @(negedge clk);
        acc = vld && req_rdy_o;
        @(posedge clk);
        if (fl) q.delete();
        if (acc && ok) q.push_back(e);
        exp_err = acc && !ok;
        #1;
    endtask

    task automatic idle(input bit lrdy, input bit srdy, input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 5'd0, 2'd0, 1'b0, AMOSWAP, lrdy, srdy, 1'b0);
    endtask

    task automatic check_reset_outputs();
        chk("rst_ld_vld", l1d_ld_req_vld_o, 64'd0);
        chk("rst_st_vld", l1d_st_req_vld_o, 64'd0);
        chk("rst_err", req_err_o, 64'd0);
        chk("rst_cnt", fifo_cnt_o, 64'd0);
        chk("rst_ld_op", l1d_ld_req_opcode_o, 64'd0);
        chk("rst_ld_tag", l1d_ld_req_tag_o, 64'd0);
        chk("rst_st_op", l1d_st_req_opcode_o, 64'd0);
        chk("rst_st_paddr", l1d_st_req_paddr_o, 64'd0);
        chk("rst_st_data", l1d_st_req_data_o, 64'd0);
    endtask

    initial begin
        #2;
        check_reset_outputs();
        chk("rst_rdy", req_rdy_o, 64'd1);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        cyc(1'b1, C_LD, 2'd0, 1'b1, AMOSWAP, 1'b0, 1'b0, 1'b0);
        idle(1'b1, 1'b0, 2);
        cyc(1'b1, C_AMO, 2'd3, 1'b1, AMOMAX, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, C_AMO, 2'd2, 1'b0, AMOADD, 1'b0, 1'b0, 1'b0);
        idle(1'b0, 1'b1, 3);
        cyc(1'b1, C_LR, 2'd1, 1'b0, AMOSWAP, 1'b0, 1'b0, 1'b0);
        idle(1'b0, 1'b0, 2);
        for (int i = 0; i < 5; i++) cyc(1'b1, C_ST, 2'(i), 1'b0, AMOSWAP, 1'b0, 1'b0, 1'b0);
        idle(1'b0, 1'b1, 1);
        cyc(1'b1, C_ST, 2'd3, 1'b0, AMOSWAP, 1'b0, 1'b1, 1'b0);
        idle(1'b0, 1'b1, 4);
        cyc(1'b1, C_LD, 2'd2, 1'b0, AMOSWAP, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, C_ST, 2'd1, 1'b0, AMOSWAP, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, C_LD, 2'd3, 1'b0, AMOSWAP, 1'b1, 1'b0, 1'b0);
        idle(1'b1, 1'b0, 3);
        idle(1'b1, 1'b1, 3);
        for (int i = 0; i < 3; i++) cyc(1'b1, C_SC, 2'd3, 1'b0, AMOSWAP, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, C_ST, 2'd0, 1'b0, AMOSWAP, 1'b0, 1'b0, 1'b1);
        idle(1'b1, 1'b1, 2);
        for (int i = 0; i < 3000; i++) begin
            bit [4:0] cls;
            cls = ($urandom_range(0, 9) == 0) ? 5'($urandom()) : (5'd1 << $urandom_range(0, 4));
            cyc($urandom_range(0, 3) != 0, cls, 2'($urandom()), $urandom_range(0, 3) == 0,
                amo_type_t'($urandom_range(0, 6)), 1'($urandom()), 1'($urandom()), $urandom_range(0, 40) == 0);
        end
        for (int i = 0; i < 3; i++) cyc(1'b1, C_AMO, 2'd2, 1'b0, AMOXOR, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        check_reset_outputs();
        q.delete();
        exp_err = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        cyc(1'b1, C_LD, 2'd1, 1'b0, AMOSWAP, 1'b1, 1'b1, 1'b0);
        idle(1'b1, 1'b1, 3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
